// File: rtl/fibonacci_calculator_if.sv
// Handshake bundle between the Fibonacci engine and its requester.
// The master side issues start_i/n_i; the slave side returns status and result.
interface fibonacci_calculator_if #(
  parameter int unsigned IW = 5,
  parameter int unsigned N  = 14
);
  logic          start_i;
  logic [IW-1:0] n_i;
  logic          ready_o;
  logic          done_o;
  logic [N-1:0]  fib_o;
  logic          overflow_o;

  modport master (
    output start_i, n_i,
    input  ready_o, done_o, fib_o, overflow_o
  );

  modport slave (
    input  start_i, n_i,
    output ready_o, done_o, fib_o, overflow_o
  );
endinterface

// File: rtl/fibonacci_calculator.sv
// Iterative Fibonacci engine: one addition per clock, result held until the
// next completion. Overflow flags travel with the values they describe.
// Optional macro FIB_DECIMAL_CLAMP_EN: clamp results to the 4-digit BCD range
// (9999) and flag anything larger, for the downstream binary->BCD display path.
module fibonacci_calculator #(
  parameter int unsigned IW = 5,
  parameter int unsigned N  = 14
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  fibonacci_calculator_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  t0;
  logic [N-1:0]  t1;
  logic [IW-1:0] count;
  logic          ov0;
  logic          ov1;
  logic [N-1:0]  fib_q;
  logic          ovf_q;

  logic [N:0]    sum;
  logic [N-1:0]  res_fib;
  logic          res_ovf;

  assign sum = {1'b0, t0} + {1'b0, t1};

  assign bus.ready_o    = (state == IDLE);
  assign bus.done_o     = (state == DONE);
  assign bus.fib_o      = fib_q;
  assign bus.overflow_o = ovf_q;

`ifdef FIB_DECIMAL_CLAMP_EN
  localparam logic [N-1:0] BCD_MAX = N'(9999);

  if (N < 14) begin : g_width_check
    $error("fibonacci_calculator: FIB_DECIMAL_CLAMP_EN needs N >= 14");
  end

  // Result selection: saturate anything that will not fit four BCD digits
  always_comb begin
    res_fib = t0;
    res_ovf = 1'b0;
    if (ov0 || (t0 > BCD_MAX)) begin
      res_fib = BCD_MAX;
      res_ovf = 1'b1;
    end
  end
`else
  // Result selection: pass the wrapped N-bit value and its sticky flag
  always_comb begin
    res_fib = t0;
    res_ovf = ov0;
  end
`endif

  // Control FSM plus datapath registers; results update only on OP->DONE
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      t0    <= '0;
      t1    <= '0;
      count <= '0;
      ov0   <= 1'b0;
      ov1   <= 1'b0;
      fib_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            t0    <= '0;
            t1    <= N'(1);
            ov0   <= 1'b0;
            ov1   <= 1'b0;
            count <= bus.n_i;
            state <= OP;
          end
        end
        OP: begin
          if (count != '0) begin
            t0    <= t1;
            t1    <= sum[N-1:0];
            ov0   <= ov1;
            ov1   <= ov0 | ov1 | sum[N];
            count <= count - 1'b1;
          end else begin
            fib_q <= res_fib;
            ovf_q <= res_ovf;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_calculator.sv
// Scoreboard bench for fibonacci_calculator: a reference model pushes the
// expected result on every accepted start; a monitor pops on done_o.
module tb_fibonacci_calculator;

  localparam int unsigned IW = 5;
  localparam int unsigned N  = 14;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fibonacci_calculator_if #(.IW(IW), .N(N)) bus ();

  fibonacci_calculator #(.IW(IW), .N(N)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  typedef struct {
    int unsigned  n;
    logic [N-1:0] fib;
    logic         ovf;
    int unsigned  dcyc;
  } exp_t;

  exp_t         sb[$];
  int unsigned  total = 0;
  int unsigned  bad   = 0;
  int unsigned  cyc   = 0;
  int unsigned  busy  = 0;
  logic [N-1:0] last_fib = '0;
  logic         last_ovf = 1'b0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-computed fib(n) mod 2^14 and whether fib(n) >= 2^14
  function automatic exp_t lookup(input int unsigned n);
    exp_t e;
    e.n    = n;
    e.dcyc = 0;
    e.ovf  = 1'b0;
    case (n)
      0:  e.fib = 14'd0;
      1:  e.fib = 14'd1;
      2:  e.fib = 14'd1;
      3:  e.fib = 14'd2;
      5:  e.fib = 14'd5;
      7:  e.fib = 14'd13;
      9:  e.fib = 14'd34;
      10: e.fib = 14'd55;
      12: e.fib = 14'd144;
      20: e.fib = 14'd6765;
      21: e.fib = 14'd10946;
      22: begin e.fib = 14'd1327; e.ovf = 1'b1; end  // 17711
      25: begin e.fib = 14'd9489; e.ovf = 1'b1; end  // 75025
      31: begin e.fib = 14'd2781; e.ovf = 1'b1; end  // 1346269
      default: begin
        e.fib = '0;
        $display("FAIL lookup: got index %0d expected an index in the table", n);
      end
    endcase
`ifdef FIB_DECIMAL_CLAMP_EN
    if (e.ovf || e.fib > 14'd9999) begin
      e.fib = 14'd9999;
      e.ovf = 1'b1;
    end
`endif
    return e;
  endfunction

  // Reference model: acceptance, busy tracking and expected done cycle
  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      busy     = 0;
      cyc      = 0;
      last_fib = '0;
      last_ovf = 1'b0;
      sb.delete();
    end else begin
      cyc++;
      if (busy == 0 && bus.start_i === 1'b1) begin
        e      = lookup(int'(bus.n_i));
        e.dcyc = cyc + e.n + 1;
        sb.push_back(e);
        busy   = e.n + 2;
      end else if (busy > 0) begin
        busy--;
      end
    end
  end

  // Monitor: ready, completion timing, result values and result hold
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("ready_o", bus.ready_o, (busy == 0) ? 1 : 0);
      if (sb.size() > 0 && cyc > sb[0].dcyc) begin
        e = sb.pop_front();
        chk("done_missing", 0, e.n + 100);
      end
      if (bus.done_o === 1'b1) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("fib_o", bus.fib_o, e.fib);
          chk("overflow_o", bus.overflow_o, e.ovf);
          chk("done_cycle", cyc, e.dcyc);
          last_fib = e.fib;
          last_ovf = e.ovf;
        end
      end else begin
        chk("done_o_low", bus.done_o, 0);
        chk("fib_hold", bus.fib_o, last_fib);
        chk("ovf_hold", bus.overflow_o, last_ovf);
      end
    end
  end

  task automatic issue(input int unsigned n);
    int unsigned w = 0;
    while (busy != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) chk("issue_wait", w, 0);
    bus.start_i = 1'b1;
    bus.n_i     = IW'(n);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.n_i     = IW'($urandom);
  endtask

  task automatic drain();
    int unsigned w = 0;
    while ((sb.size() != 0 || busy != 0) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) chk("drain_wait", w, 0);
  endtask

  initial begin
    int unsigned vec[10] = '{0, 1, 2, 5, 10, 20, 21, 22, 25, 31};
    int unsigned tog[6]  = '{3, 7, 0, 12, 1, 9};

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.n_i     = '0;
    repeat (3) @(negedge clk);
    chk("rst_fib_o", bus.fib_o, 0);
    chk("rst_overflow_o", bus.overflow_o, 0);
    chk("rst_done_o", bus.done_o, 0);
    chk("rst_ready_o", bus.ready_o, 1);
    rst = 1'b0;
    @(negedge clk);

    // Directed indices, issued back to back at the minimum period
    foreach (vec[i]) issue(vec[i]);
    drain();

    // start_i held high while n_i changes every cycle
    bus.start_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bus.n_i = IW'(tog[i % 6]);
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    drain();

    // Reset in the middle of a long computation
    issue(20);
    drain();
    issue(31);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_fib_o", bus.fib_o, 0);
    chk("midrst_overflow_o", bus.overflow_o, 0);
    chk("midrst_done_o", bus.done_o, 0);
    chk("midrst_ready_o", bus.ready_o, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(10);
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
